// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a valid/ready request port and a held result port.
// Logic, add, and shift ops finish one cycle after acceptance. MUL runs as an
// iterative shift-add over WIDTH clocks.
module alu_mc #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FS,
  input  logic             C0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       status,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] f_reg;
  logic [3:0]       status_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [SHW-1:0]   cnt_reg;

  logic             accept;
  logic             op_is_mul;
  logic             mul_last;
  logic [WIDTH-1:0] a_op, b_op;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_v, alu_c;
  logic [WIDTH-1:0] acc_step;

  // Handshake and status outputs come straight from the state register.
  assign in_ready  = rst_n & ((state_reg == S_IDLE) | ((state_reg == S_DONE) & out_ready));
  assign out_valid = (state_reg == S_DONE);
  assign busy      = (state_reg == S_MUL);
  assign F         = f_reg;
  assign status    = status_reg;

  assign accept    = in_valid & in_ready;
  assign op_is_mul = (FS[4:2] == OP_MUL);
  assign mul_last  = (cnt_reg == SHW'(WIDTH - 1));

  // Inverted operands only feed the logic/add ops. Shifts and MUL see raw A/B.
  assign a_op  = FS[1] ? ~A : A;
  assign b_op  = FS[0] ? ~B : B;
  assign sum   = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, C0};
  assign shamt = B[SHW-1:0];

  // One shift-add step: add the multiplicand when the current multiplier LSB is set.
  assign acc_step = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  // Single-cycle result for every op except MUL. MUL and op 111 yield zero here.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (FS[4:2])
      OP_AND: alu_res = a_op & b_op;
      OP_OR:  alu_res = a_op | b_op;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ~(a_op[MSB] ^ b_op[MSB]) & (sum[MSB] ^ a_op[MSB]);
      end
      OP_XOR: alu_res = a_op ^ b_op;
      OP_SHL: alu_res = A << shamt;
      OP_SHR: alu_res = A >> shamt;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic. DONE can retire and accept on the same edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_next = op_is_mul ? S_MUL : S_DONE;
        end else if ((state_reg == S_DONE) && out_ready) begin
          state_next = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_last) begin
          state_next = S_DONE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Result and flag registers. They only change when a new result is produced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_reg      <= '0;
      status_reg <= '0;
    end else if (accept && !op_is_mul) begin
      f_reg      <= alu_res;
      status_reg <= {alu_v, alu_c, alu_res[MSB], (alu_res == '0)};
    end else if ((state_reg == S_MUL) && mul_last) begin
      f_reg      <= acc_step;
      status_reg <= {2'b00, acc_step[MSB], (acc_step == '0)};
    end
  end

  // Multiplier datapath: load on MUL acceptance, then one step per clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else if (accept && op_is_mul) begin
      acc_reg    <= '0;
      mcand_reg  <= A;
      mplier_reg <= B;
      cnt_reg    <= '0;
    end else if (state_reg == S_MUL) begin
      acc_reg    <= acc_step;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc.
// It drives a 64-bit instance and an 8-bit instance, which share clock and reset.
module tb_alu_mc;

  typedef struct {
    int          id;
    logic [63:0] f;
    logic [3:0]  st;
    int          lat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  fs;
    logic        c0;
    logic [63:0] f;
    logic [3:0]  st;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy, c0;
  logic [63:0] a, b, f;
  logic [4:0]  fs;
  logic [3:0]  status;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8, c08;
  logic [7:0]  a8, b8, f8;
  logic [4:0]  fs8;
  logic [3:0]  status8;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t q[$];
  exp_t q8[$];
  exp_t cur, cur8;
  bit   have  = 1'b0;
  bit   have8 = 1'b0;
  vec_t vecs[10];

  alu_mc #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .FS(fs), .C0(c0), .out_valid(out_valid), .out_ready(out_ready),
    .F(f), .status(status), .busy(busy)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .FS(fs8), .C0(c08), .out_valid(out_valid8), .out_ready(out_ready8),
    .F(f8), .status(status8), .busy(busy8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for in_ready, and optionally push the expected result.
  task automatic issue(input bit w8, input int id, input logic [63:0] ia, input logic [63:0] ib,
                       input logic [4:0] ifs, input logic ic0, input logic [63:0] ef,
                       input logic [3:0] est, input int lat, input bit push);
    exp_t e;
    bit   done;
    done = 1'b0;
    if (w8) begin
      in_valid8 = 1'b1; a8 = ia[7:0]; b8 = ib[7:0]; fs8 = ifs; c08 = ic0;
    end else begin
      in_valid = 1'b1; a = ia; b = ib; fs = ifs; c0 = ic0;
    end
    for (int i = 0; i < 300 && !done; i++) begin
      #1;
      if (w8 ? in_ready8 : in_ready) begin
        e.id = id; e.f = ef; e.st = est; e.lat = lat; e.acc_cyc = cyc + 1;
        if (push) begin
          if (w8) q8.push_back(e);
          else q.push_back(e);
        end
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      n_checks++;
      $display("FAIL v%0d_accept: in_ready never rose, required 1", id);
    end
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
  endtask

  // 64-bit monitor: pop when a new result appears, check it every cycle it is held.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!have) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got F=0x%0h, required no output", f);
        end else begin
          cur  = q.pop_front();
          have = 1'b1;
          $display("txn v%0d F=0x%0h status=%b", cur.id, f, status);
          chk($sformatf("v%0d_latency", cur.id), 64'(cyc - cur.acc_cyc + 1), 64'(cur.lat));
        end
      end
      if (have) begin
        chk($sformatf("v%0d_F", cur.id), f, cur.f);
        chk($sformatf("v%0d_status", cur.id), 64'(status), 64'(cur.st));
      end
      if (out_ready) have = 1'b0;
    end
  end

  // 8-bit monitor: same scheme as the 64-bit monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid8) begin
      if (!have8) begin
        if (q8.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result8: got F=0x%0h, required no output", f8);
        end else begin
          cur8  = q8.pop_front();
          have8 = 1'b1;
          $display("txn v%0d F=0x%0h status=%b", cur8.id, f8, status8);
          chk($sformatf("v%0d_latency", cur8.id), 64'(cyc - cur8.acc_cyc + 1), 64'(cur8.lat));
        end
      end
      if (have8) begin
        chk($sformatf("v%0d_F", cur8.id), 64'(f8), cur8.f);
        chk($sformatf("v%0d_status", cur8.id), 64'(status8), 64'(cur8.st));
      end
      if (out_ready8) have8 = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int ir_bad;
    vecs[0] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, 64'h8000_0000_0000_0000, 4'b1010};
    vecs[1] = '{64'd5, 64'd5, 5'b01001, 1'b1, 64'd0, 4'b0101};
    vecs[2] = '{64'hF0F0, 64'hFF00, 5'b00000, 1'b0, 64'hF000, 4'b0000};
    vecs[3] = '{64'd0, 64'd0, 5'b00110, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010};
    vecs[4] = '{64'hFF, 64'h0F, 5'b01100, 1'b0, 64'hF0, 4'b0000};
    vecs[5] = '{64'h123, 64'h456, 5'b11100, 1'b0, 64'd0, 4'b0001};
    vecs[6] = '{64'd1, 64'd63, 5'b10011, 1'b0, 64'h8000_0000_0000_0000, 4'b0010};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h43, 5'b10100, 1'b0, 64'h1000_0000_0000_0000, 4'b0000};
    vecs[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, 64'd0, 4'b0101};
    vecs[9] = '{64'd7, 64'd6, 5'b11011, 1'b0, 64'h2A, 4'b0000};

    rst_n = 1'b0; out_ready = 1'b1; out_ready8 = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; fs = '0; c0 = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; fs8 = '0; c08 = 1'b0;

    // Reset state
    repeat (3) tick();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    chk("rst_F", f, 64'd0);
    chk("rst_status", 64'(status), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready_release", 64'(in_ready), 64'd1);
    tick();

    // Directed single-cycle and small MUL vectors, issued back-to-back
    for (int i = 0; i < 10; i++) begin
      issue(1'b0, i, vecs[i].a, vecs[i].b, vecs[i].fs, vecs[i].c0, vecs[i].f, vecs[i].st,
            (vecs[i].fs[4:2] == 3'b110) ? 65 : 1, 1'b1);
    end

    // Full-width MUL: busy for 64 cycles with in_ready low, result after 65 cycles
    issue(1'b0, 10, 64'hFFFF_FFFF, 64'h1_0000_0001, 5'b11000, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 65, 1'b1);
    bc = 0; ir_bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (busy) bc++;
      if (in_ready) ir_bad++;
    end
    chk("mul_busy_cycles", 64'(bc), 64'd64);
    chk("mul_in_ready_high_cycles", 64'(ir_bad), 64'd0);
    tick();

    // IDLE keeps the last result with out_valid low
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_F_retained", f, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("idle_status_retained", 64'(status), 64'd2);

    // Backpressure: hold for 5 cycles, then retire and accept on the same edge
    out_ready = 1'b0;
    issue(1'b0, 11, 64'hC, 64'hA, 5'b00000, 1'b0, 64'h8, 4'b0000, 1, 1'b1);
    repeat (5) tick();
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    issue(1'b0, 12, 64'hFF, 64'h3C, 5'b00000, 1'b0, 64'h3C, 4'b0000, 1, 1'b1);
    tick();
    tick();

    // Reset at MUL step 10 discards the operation
    issue(1'b0, 99, 64'd3, 64'd5, 5'b11000, 1'b0, 64'd15, 4'b0000, 65, 1'b0);
    repeat (9) tick();
    chk("mid_mul_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    #1;
    chk("mulrst_out_valid", 64'(out_valid), 64'd0);
    chk("mulrst_busy", 64'(busy), 64'd0);
    chk("mulrst_F", f, 64'd0);
    chk("mulrst_status", 64'(status), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("mulrst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Recovery after reset
    issue(1'b0, 13, 64'd2, 64'd3, 5'b01000, 1'b1, 64'd6, 4'b0000, 1, 1'b1);

    // 8-bit instance: shifts, overflow, and truncated MUL
    issue(1'b1, 20, 64'h81, 64'h09, 5'b10000, 1'b0, 64'h02, 4'b0000, 1, 1'b1);
    issue(1'b1, 21, 64'h81, 64'h09, 5'b10100, 1'b0, 64'h40, 4'b0000, 1, 1'b1);
    issue(1'b1, 22, 64'h7F, 64'h01, 5'b01000, 1'b0, 64'h80, 4'b1010, 1, 1'b1);
    issue(1'b1, 23, 64'h10, 64'h10, 5'b11000, 1'b0, 64'h00, 4'b0001, 9, 1'b1);

    repeat (15) tick();
    chk("q64_drained", 64'(q.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
